// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit controller and its baud counter.
//   tx_state_e       : controller FSM encoding (IDLE, LOAD, RUN)
//   BAUD_DIV_DEFAULT : clock cycles per bit for 50 MHz / 115200 baud
//   START_BIT        : line level of the start bit
//   STOP_BIT         : line level of the stop bit (also the idle level)
//   PARITY_BITS      : 1 when UART_TX_PARITY_EN is defined, otherwise 0
// Optional feature macro: UART_TX_PARITY_EN (even parity bit in the frame).
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } tx_state_e;

    localparam int BAUD_DIV_DEFAULT = 434;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

`ifdef UART_TX_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/uart_tx_controller_if.sv
// -----------------------------------------------------------------------------
// uart_tx_controller_if
// Byte handshake between the UART register file (master) and the transmit
// controller (slave).
//   tx_data  : byte to send, sampled on the handshake   (master -> slave)
//   tx_valid : requester has a byte                     (master -> slave)
//   tx_ready : controller can accept a byte             (slave -> master)
//   tx_busy  : frame in progress                        (slave -> master)
//   tx_done  : one-cycle pulse at the end of a frame    (slave -> master)
// -----------------------------------------------------------------------------
interface uart_tx_controller_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, tx_busy, tx_done
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, tx_busy, tx_done
    );

endinterface

// File: rtl/uart_baud_tick.sv
// -----------------------------------------------------------------------------
// uart_baud_tick
// Bit-period counter: counts 0..BAUD_DIV-1 while enabled and flags the
// terminal count. The tick cycle itself returns the count to zero.
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-low reset
//   clear : synchronous clear to zero (has priority over counting)
//   en    : count enable
//   tick  : high in the cycle the count sits at BAUD_DIV-1 while enabled
// -----------------------------------------------------------------------------
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    localparam int               CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] TERM  = CNT_W'(BAUD_DIV - 1);

    logic [CNT_W-1:0] baud_cnt;

    assign tick = en && (baud_cnt == TERM);

    // NOTE: state registers take non-blocking (<=) assignments so every flop
    // samples the pre-edge values of the others; blocking (=) here would
    // create order-dependent simulation that need not match the netlist.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= '0;
        end else if (clear || tick) begin
            baud_cnt <= '0;
        end else if (en) begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// -----------------------------------------------------------------------------
// uart_tx_controller
// Sequences the UART transmit shifter: accepts a byte over a valid/ready
// handshake, presents the frame word, pulses the shifter's parallel load once,
// then pulses its shift input once per bit period until the whole frame
// (stop bit included) has been on the line for BAUD_DIV cycles per bit.
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   tx         : byte handshake (slave side of uart_tx_controller_if)
//   shift_load : to the shifter's parallel-load enable (LOAD state)
//   shift_en   : to the shifter's shift input (one pulse per bit period)
//   shift_data : frame word {STOP, [parity], data, START} for the shifter's D
// Optional feature macro: UART_TX_PARITY_EN inserts an even-parity bit between
// the data MSB and the stop bit (FRAME_BITS = DATA_BITS+3 instead of +2).
// -----------------------------------------------------------------------------
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter  int BAUD_DIV   = BAUD_DIV_DEFAULT,
    parameter  int DATA_BITS  = 8,
    localparam int FRAME_BITS = DATA_BITS + 2 + PARITY_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_controller_if.slave   tx,
    output logic                  shift_load,
    output logic                  shift_en,
    output logic [FRAME_BITS-1:0] shift_data
);

    localparam int               BIT_W    = $clog2(FRAME_BITS + 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);

    tx_state_e            state;
    tx_state_e            state_nxt;
    logic [DATA_BITS-1:0] data_hold;
    logic [BIT_W-1:0]     bit_cnt;
    logic                 tick;
    logic                 accept;
    logic                 ready;
    logic                 busy;
    logic                 done;

    // The baud counter is held at zero outside RUN, so the first tick of a
    // frame lands exactly BAUD_DIV cycles after the LOAD cycle.
    uart_baud_tick #(
        .BAUD_DIV (BAUD_DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (state != RUN),
        .en    (state == RUN),
        .tick  (tick)
    );

    // NOTE: every output of this block gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt  = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        shift_load = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (tx.tx_valid) begin
                    accept    = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                shift_load = 1'b1;
                state_nxt  = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (tick) begin
                    shift_en = 1'b1;
                    // Ticking on the last frame bit ends the frame; the stop
                    // bit has then been on the line for a full bit period.
                    if (bit_cnt == LAST_BIT) begin
                        done      = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: data_hold is reset even though it is only read after a capture,
    // because shift_data is a visible port and must be defined out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_hold <= '0;
            bit_cnt   <= '0;
        end else begin
            if (accept) begin
                data_hold <= tx.tx_data;
            end
            if (state == LOAD) begin
                bit_cnt <= '0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    assign shift_data = {STOP_BIT, ^data_hold, data_hold, START_BIT};
`else
    assign shift_data = {STOP_BIT, data_hold, START_BIT};
`endif

    assign tx.tx_ready = ready;
    assign tx.tx_busy  = busy;
    assign tx.tx_done  = done;

endmodule

// File: tb/tb_uart_tx_controller.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_controller
// Drives uart_tx_controller (BAUD_DIV=4, DATA_BITS=8) wired to a PISO shifter
// model that lives in the bench. Stimulus pushes the expected frame and the
// accept cycle into a scoreboard queue; an independent monitor pops it at the
// LOAD cycle and checks every control output, the frame word and the serial
// line cycle by cycle. Honors UART_TX_PARITY_EN for the parity build.
// -----------------------------------------------------------------------------
module tb_uart_tx_controller;

    localparam int BAUD = 4;
    localparam int DB   = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam logic [7:0]    SINGLE_BYTE  = 8'h07;
    localparam logic [FB-1:0] SINGLE_FRAME = 11'b1_1_00000111_0;
    localparam logic [7:0]    PAIR_A_BYTE  = 8'h07;
    localparam logic [FB-1:0] PAIR_A_FRAME = 11'b1_1_00000111_0;
    localparam logic [7:0]    PAIR_B_BYTE  = 8'h03;
    localparam logic [FB-1:0] PAIR_B_FRAME = 11'b1_0_00000011_0;
    localparam logic [7:0]    RST_BYTE     = 8'h5A;
    localparam logic [FB-1:0] RST_FRAME    = 11'b1_0_01011010_0;
    localparam logic [FB-1:0] RESET_WORD   = 11'b1_0_00000000_0;
`else
    localparam int FB = 10;
    localparam logic [7:0]    SINGLE_BYTE  = 8'hA5;
    localparam logic [FB-1:0] SINGLE_FRAME = 10'b1_10100101_0;
    localparam logic [7:0]    PAIR_A_BYTE  = 8'h00;
    localparam logic [FB-1:0] PAIR_A_FRAME = 10'b1_00000000_0;
    localparam logic [7:0]    PAIR_B_BYTE  = 8'hFF;
    localparam logic [FB-1:0] PAIR_B_FRAME = 10'b1_11111111_0;
    localparam logic [7:0]    RST_BYTE     = 8'h5A;
    localparam logic [FB-1:0] RST_FRAME    = 10'b1_01011010_0;
    localparam logic [FB-1:0] RESET_WORD   = 10'b1_00000000_0;
`endif

    typedef struct {
        logic [FB-1:0] frame;
        int            acc;
    } exp_t;

    logic          clk;
    logic          rst;
    logic          shift_load;
    logic          shift_en;
    logic [FB-1:0] shift_data;
    logic [FB-1:0] sh;
    logic          q;
    int            cyc = 0;
    int            n_vec = 0;
    int            n_err = 0;
    exp_t          sb[$];

    uart_tx_controller_if #(.DATA_BITS(DB)) tx_if ();

    uart_tx_controller #(
        .BAUD_DIV  (BAUD),
        .DATA_BITS (DB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx         (tx_if.slave),
        .shift_load (shift_load),
        .shift_en   (shift_en),
        .shift_data (shift_data)
    );

    // PISO shifter: parallel load, LSB first, fills with 1s; line is bit 0.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh <= '1;
        end else if (shift_load) begin
            sh <= shift_data;
        end else if (shift_en) begin
            sh <= {1'b1, sh[FB-1:1]};
        end
    end
    assign q = sh[0];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    bit            mon_active = 1'b0;
    exp_t          cur;
    int            load_cyc = 0;
    int            rel;
    logic          exp_load;
    logic          exp_en;
    logic          exp_done;
    logic          exp_q;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_active = 1'b0;
                sb.delete();
            end else if (!mon_active && sb.size() > 0 && cyc == sb[0].acc + 1) begin
                cur        = sb.pop_front();
                mon_active = 1'b1;
                load_cyc   = cyc;
            end
            rel      = cyc - load_cyc;
            exp_load = mon_active && (rel == 0);
            exp_en   = mon_active && (rel > 0) && (rel % BAUD == 0);
            exp_done = exp_en && (rel == FB * BAUD);
            exp_q    = (mon_active && rel > 0) ? cur.frame[(rel - 1) / BAUD] : 1'b1;
            check("shift_load", 32'(shift_load), 32'(exp_load));
            check("shift_en", 32'(shift_en), 32'(exp_en));
            check("tx_done", 32'(tx_if.tx_done), 32'(exp_done));
            check("tx_busy", 32'(tx_if.tx_busy), 32'(mon_active));
            check("tx_ready", 32'(tx_if.tx_ready), 32'(!mon_active));
            check("line_q", 32'(q), 32'(exp_q));
            if (mon_active) begin
                check("shift_data", 32'(shift_data), 32'(cur.frame));
            end
            if (exp_done) begin
                mon_active = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after the capture edge.
    task automatic send(input logic [7:0] d, input logic [FB-1:0] f, input bit hold,
                        output int acc);
        bit ok = 1'b0;
        acc = -1;
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_if.tx_ready) begin
                ok  = 1'b1;
                acc = cyc;
                sb.push_back('{frame: f, acc: cyc});
                break;
            end
        end
        check("accept", 32'(ok), 32'd1);
        @(posedge clk);
        #1;
        if (!hold) begin
            tx_if.tx_valid = 1'b0;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx_if.tx_done) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, 32'(seen), 32'd1);
        @(posedge clk);
        #1;
    endtask

    int acc_a;
    int acc_b;

    initial begin
        rst            = 1'b0;
        tx_if.tx_data  = '0;
        tx_if.tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_shift_data", 32'(shift_data), 32'(RESET_WORD));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single frame, with a rejected request while it is in flight.
        send(SINGLE_BYTE, SINGLE_FRAME, 1'b0, acc_a);
        repeat (10) @(posedge clk);
        #1;
        tx_if.tx_data  = 8'h3C;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        check("busy_ready", 32'(tx_if.tx_ready), 32'd0);
        check("busy_busy", 32'(tx_if.tx_busy), 32'd1);
        @(posedge clk);
        #1;
        tx_if.tx_valid = 1'b0;
        tx_if.tx_data  = '0;
        wait_done("single_done");

        // Back-to-back with tx_valid held high across both frames.
        send(PAIR_A_BYTE, PAIR_A_FRAME, 1'b1, acc_a);
        send(PAIR_B_BYTE, PAIR_B_FRAME, 1'b0, acc_b);
        check("b2b_gap", 32'(acc_b - acc_a), 32'(FB * BAUD + 2));
        wait_done("b2b_done");

        // Reset in the middle of a frame abandons it without tx_done.
        send(RST_BYTE, RST_FRAME, 1'b0, acc_a);
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
        check("rst_busy", 32'(tx_if.tx_busy), 32'd0);
        check("rst_done", 32'(tx_if.tx_done), 32'd0);
        check("rst_load", 32'(shift_load), 32'd0);
        check("rst_en", 32'(shift_en), 32'd0);
        check("rst_q", 32'(q), 32'd1);
        check("rst_data", 32'(shift_data), 32'(RESET_WORD));
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (60) @(negedge clk);
        @(posedge clk);
        #1;

        // Recovery after the abandoned frame.
        send(SINGLE_BYTE, SINGLE_FRAME, 1'b0, acc_a);
        wait_done("recover_done");
        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_controller.md
Name: uart_tx_controller

Overview:
- Sequences the UART transmit datapath: the parametric right-shift PISO register (parallel load, LSB-first shift, fills with 1s).
- Accepts a byte over a valid/ready handshake and builds the frame word (start, data, optional parity, stop).
- Pulses the shifter's load input, then pulses its shift input once per bit period.
- Sits between the bus-side UART register file and the TX shifter; the serial line is the shifter's q output.

Parameters:
- BAUD_DIV, 434, clock cycles per bit; must be >= 2. Default is 50 MHz / 115200.
- DATA_BITS, 8, payload width.
- FRAME_BITS (localparam), DATA_BITS+2, or DATA_BITS+3 with parity; width of shift_data.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- tx_data  in  DATA_BITS  byte to send; sampled on handshake.
- tx_valid  in  1  requester has a byte.
- tx_ready  out  1  controller can accept a byte.
- tx_busy  out  1  frame in progress.
- tx_done  out  1  one-cycle pulse at end of frame.
- shift_load  out  1  to the shifter's enable (parallel load).
- shift_en  out  1  to the shifter's shift input.
- shift_data  out  FRAME_BITS  to the shifter's D; value is {1'b1, [parity], data, 1'b0}.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; baud_cnt=0; bit_cnt=0; data_hold=0.
  - shift_load=0, shift_en=0, tx_done=0, tx_busy=0, tx_ready=1 (tx_ready is decoded from IDLE).
  - Reset mid-frame abandons the frame with no tx_done. The shifter's own reset returns the line to 1.
- States: IDLE, LOAD, RUN.
- IDLE:
  - tx_ready=1.
  - On tx_valid&&tx_ready: tx_data is captured into data_hold and the FSM moves to LOAD.
- LOAD (exactly 1 cycle):
  - shift_load=1; baud_cnt<=0; bit_cnt<=0; next state RUN.
  - Call this cycle L.
- RUN:
  - baud_cnt increments each cycle.
  - When baud_cnt==BAUD_DIV-1: shift_en=1 for that cycle, baud_cnt<=0, bit_cnt<=bit_cnt+1.
  - Shift pulses fall on cycles L+k*BAUD_DIV, k=1..FRAME_BITS. Every frame bit, stop included, is therefore on the line for exactly BAUD_DIV cycles.
  - On the FRAME_BITS-th pulse (bit_cnt==FRAME_BITS-1 at the tick): tx_done=1 in the same cycle, next state IDLE.
- Handshake rules:
  - tx_busy=1 in LOAD and RUN; tx_ready=0 there, and tx_valid is ignored.
  - tx_ready returns 1 in the cycle after tx_done.
  - Back-to-back: a valid held high is accepted that cycle, with no idle gap beyond the one handshake cycle.
- Output timing: shift_load and shift_en are registered-decode, mutually exclusive, never both high.
- shift_data is driven from data_hold and is stable from LOAD through the end of the frame.
- Total frame time from the accept edge to tx_done: 1 + FRAME_BITS*BAUD_DIV cycles.
- Widths:
  - baud_cnt is $clog2(BAUD_DIV) bits.
  - bit_cnt is $clog2(FRAME_BITS+1) bits.
  - Counters never exceed their terminal count; no wrap except the explicit clear.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Even parity bit (XOR of data_hold) is inserted between the MSB data bit and the stop bit.
  - FRAME_BITS=DATA_BITS+3 (11 for 8N bytes).
- Undefined:
  - No parity; FRAME_BITS=DATA_BITS+2 (10).
  - No parity logic exists.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding (IDLE=2'd0, LOAD=2'd1, RUN=2'd2).
  - Default BAUD_DIV constant.
  - START_BIT=1'b0, STOP_BIT=1'b1.
- One sub-module: uart_baud_tick (counter with clear input and terminal-count tick output, parameter BAUD_DIV). The FSM, bit counter and frame builder stay in uart_tx_controller.

Test Plan:
All tests use BAUD_DIV=4, DATA_BITS=8, no parity unless stated, with the controller wired to the PISO shifter.
- Reset: rst=0 mid-RUN, then release -> all outputs 0 except tx_ready=1; no tx_done; line (q) =1.
- Single byte 0xA5:
  - shift_load high exactly 1 cycle after the accept.
  - shift_data=10'b1_10100101_0.
  - 10 shift_en pulses, 4 cycles apart.
  - q sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles.
  - tx_done on the 10th pulse, cycle 41 after the accept.
- Busy rejection: pulse tx_valid with 0x3C during RUN -> not captured; tx_ready=0; the frame in flight is unchanged.
- Back-to-back: tx_valid held high with 0x00 then 0xFF -> second accept in the cycle after tx_done; LOAD follows immediately; both frames bit-exact.
- UART_TX_PARITY_EN defined, bytes 0x07 and 0x03:
  - 0x07 -> parity bit 1; 0x03 -> parity bit 0.
  - 11 shift pulses; tx_done 45 cycles after the accept.
